// File: rtl/bsg_cache_nb_pkg.sv
`default_nettype none
// ============================================================================
// bsg_cache_nb_pkg: shared types and constants for the non-blocking cache.
// Revision: 1.0
// ============================================================================
package bsg_cache_nb_pkg;

  typedef enum logic [0:0] {
    e_tbuf_drain_idle,
    e_tbuf_drain_write
  } tbuf_drain_state_e;

  localparam int tbuf_drain_max_wait_default_gp = 8;

  // Keeps index fields at least one bit wide for degenerate configurations.
  function automatic int safe_clog2(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_cache_nb_tbuf_drain_age.sv
`default_nettype none
// ============================================================================
// bsg_cache_nb_tbuf_drain_age: saturating wait counter for the tbuf head entry.
// Revision: 1.0
// ============================================================================
module bsg_cache_nb_tbuf_drain_age #(
  parameter  int max_wait_p   = 8,
  localparam int age_width_lp = $clog2(max_wait_p + 1)
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic sat_o
);

  localparam logic [age_width_lp-1:0] max_age_lp = age_width_lp'(max_wait_p);

  logic [age_width_lp-1:0] age_q;
  logic [age_width_lp-1:0] age_d;

  assign sat_o = (age_q == max_age_lp);

  always_comb begin
    age_d = age_q;
    if (clear_i) begin
      age_d = '0;
    end else if (inc_i && !sat_o) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_cache_nb_tbuf_drain.sv
`default_nettype none
// ============================================================================
// bsg_cache_nb_tbuf_drain: drains tbuf head entries into data-SRAM writes with
// aging priority over the pipeline and fence support.
// Optional statistics: define BSG_CACHE_NB_TBUF_DRAIN_STATS_EN.
// Revision: 1.0
// ============================================================================
module bsg_cache_nb_tbuf_drain
  import bsg_cache_nb_pkg::*;
#(
  parameter  int addr_width_p          = 32,
  parameter  int word_width_p          = 32,
  parameter  int ways_p                = 4,
  parameter  int sets_p                = 64,
  parameter  int block_size_in_words_p = 8,
  parameter  int max_wait_p            = tbuf_drain_max_wait_default_gp,
  localparam int lg_ways_lp            = safe_clog2(ways_p),
  localparam int lg_sets_lp            = safe_clog2(sets_p),
  localparam int lg_bsiw_lp            = safe_clog2(block_size_in_words_p),
  localparam int lg_bo_lp              = $clog2(word_width_p / 8),
  localparam int sram_addr_width_lp    = lg_sets_lp + lg_bsiw_lp
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic                          tbuf_v_i,
  input  logic [addr_width_p-1:0]       tbuf_addr_i,
  input  logic [lg_ways_lp-1:0]         tbuf_way_i,
  input  logic                          tbuf_full_i,
  input  logic                          tbuf_empty_i,
  output logic                          tbuf_yumi_o,

  input  logic                          pipe_sram_busy_i,
  output logic                          pipe_stall_o,

  output logic                          sram_v_o,
  output logic [sram_addr_width_lp-1:0] sram_addr_o,
  output logic [lg_ways_lp-1:0]         sram_way_o,
  input  logic                          sram_ready_i,

  input  logic                          fence_v_i,
  output logic                          fence_done_o
`ifdef BSG_CACHE_NB_TBUF_DRAIN_STATS_EN
  ,
  output logic [31:0]                   stat_drained_o,
  output logic [31:0]                   stat_forced_o
`endif
);

  tbuf_drain_state_e               state_q, state_d;
  logic                            fence_pend_q, fence_pend_d;
  logic [sram_addr_width_lp-1:0]   sram_addr_q, sram_addr_d;
  logic [lg_ways_lp-1:0]           sram_way_q, sram_way_d;

  logic in_idle;
  logic age_sat;
  logic override;
  logic go_write;
  logic handshake;
  logic fence_done;
  logic unused_addr;

  // Tag bits above the index and the byte offset never reach the SRAM.
  assign unused_addr = ^tbuf_addr_i;

  assign in_idle    = (state_q == e_tbuf_drain_idle);
  assign override   = fence_pend_q | tbuf_full_i | age_sat;
  assign go_write   = in_idle & tbuf_v_i & (~pipe_sram_busy_i | override);
  assign handshake  = reset_n_i & ~in_idle & sram_ready_i;
  assign fence_done = reset_n_i & fence_pend_q & tbuf_empty_i & in_idle & ~tbuf_v_i;

  bsg_cache_nb_tbuf_drain_age #(
    .max_wait_p (max_wait_p)
  ) age (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (handshake),
    .inc_i     (in_idle & tbuf_v_i & ~go_write),
    .sat_o     (age_sat)
  );

  always_comb begin
    state_d      = state_q;
    fence_pend_d = fence_pend_q;
    sram_addr_d  = sram_addr_q;
    sram_way_d   = sram_way_q;

    case (state_q)
      e_tbuf_drain_idle: begin
        if (go_write) begin
          state_d     = e_tbuf_drain_write;
          sram_addr_d = tbuf_addr_i[lg_bo_lp +: sram_addr_width_lp];
          sram_way_d  = tbuf_way_i;
        end
      end
      e_tbuf_drain_write: begin
        if (sram_ready_i) begin
          state_d = e_tbuf_drain_idle;
        end
      end
      default: state_d = e_tbuf_drain_idle;
    endcase

    // A fence arriving while one is pending merges into it.
    if (fence_done) begin
      fence_pend_d = 1'b0;
    end else if (fence_v_i) begin
      fence_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= e_tbuf_drain_idle;
      fence_pend_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_way_q   <= '0;
    end else begin
      state_q      <= state_d;
      fence_pend_q <= fence_pend_d;
      sram_addr_q  <= sram_addr_d;
      sram_way_q   <= sram_way_d;
    end
  end

  // Outputs are masked while reset is asserted so an abandoned write never pops.
  assign sram_v_o     = reset_n_i & ~in_idle;
  assign sram_addr_o  = reset_n_i ? sram_addr_q : '0;
  assign sram_way_o   = reset_n_i ? sram_way_q : '0;
  assign tbuf_yumi_o  = handshake;
  assign pipe_stall_o = reset_n_i & (~in_idle | (tbuf_v_i & override));
  assign fence_done_o = fence_done;

`ifdef BSG_CACHE_NB_TBUF_DRAIN_STATS_EN
  logic [31:0] stat_drained_q, stat_drained_d;
  logic [31:0] stat_forced_q, stat_forced_d;

  always_comb begin
    stat_drained_d = stat_drained_q;
    stat_forced_d  = stat_forced_q;
    if (handshake) begin
      stat_drained_d = stat_drained_q + 32'd1;
    end
    // Only entries that actually beat a busy pipeline by age or fullness count as forced.
    if (go_write && pipe_sram_busy_i && (age_sat || tbuf_full_i)) begin
      stat_forced_d = stat_forced_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stat_drained_q <= '0;
      stat_forced_q  <= '0;
    end else begin
      stat_drained_q <= stat_drained_d;
      stat_forced_q  <= stat_forced_d;
    end
  end

  assign stat_drained_o = stat_drained_q;
  assign stat_forced_o  = stat_forced_q;
`endif

`ifndef SYNTHESIS
  a_head_held_in_write: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_q == e_tbuf_drain_write) |-> tbuf_v_i);
`endif

endmodule
`default_nettype wire
